// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the alu and regfile_datapath.
//   - Register file geometry (16 registers x 16 bits), opcode and flag widths.
//   - Opcode encodings understood by the alu.
//   - Flag bit positions inside the 5-bit flag vector {C, L, F, Z, N}.
//   - The command state machine encoding (IDLE/READ/EXEC).
package alu_pkg;

  localparam int NUM_REGS  = 16;
  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 4;
  localparam int OP_W      = 8;
  localparam int FLAG_W    = 5;

  localparam logic [OP_W-1:0] OP_WAIT = 8'h00;
  localparam logic [OP_W-1:0] OP_ADD  = 8'h05;
  localparam logic [OP_W-1:0] OP_SUB  = 8'h09;
  localparam logic [OP_W-1:0] OP_CMP  = 8'h0B;
  localparam logic [OP_W-1:0] OP_MOV  = 8'h0D;

  // Flag bit positions: carry, unsigned-lower, signed overflow, zero, negative.
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// alu: purely combinational 16-bit arithmetic unit.
// Ports:
//   a, b    - operands (a is the destination register, b the second operand)
//   opcode  - operation select (see alu_pkg)
//   result  - 16-bit result
//   flags   - {C, L, F, Z, N}
// Operations:
//   ADD      result = a + b; C = carry out, F = signed overflow
//   SUB/CMP  result = a - b; L = a < b unsigned, F = signed overflow
//   MOV      result = b
//   Z/N follow the result for the operations above. WAIT and unknown
//   opcodes give a zero result and all flags clear.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] flags
);

  logic [DATA_W:0] sum_ext;

  always_comb begin
    result  = '0;
    flags   = '0;
    sum_ext = {1'b0, a} + {1'b0, b};
    unique case (opcode)
      OP_ADD: begin
        result         = sum_ext[DATA_W-1:0];
        flags[FLAG_C]  = sum_ext[DATA_W];
        // Overflow when both operands share a sign the result does not.
        flags[FLAG_F]  = (a[DATA_W-1] == b[DATA_W-1]) &&
                         (result[DATA_W-1] != a[DATA_W-1]);
        flags[FLAG_Z]  = (result == '0);
        flags[FLAG_N]  = result[DATA_W-1];
      end
      OP_SUB, OP_CMP: begin
        result         = a - b;
        flags[FLAG_L]  = (a < b);
        // Subtraction overflows only when the operand signs differ.
        flags[FLAG_F]  = (a[DATA_W-1] != b[DATA_W-1]) &&
                         (result[DATA_W-1] != a[DATA_W-1]);
        flags[FLAG_Z]  = (result == '0);
        flags[FLAG_N]  = result[DATA_W-1];
      end
      OP_MOV: begin
        result         = b;
        flags[FLAG_Z]  = (result == '0);
        flags[FLAG_N]  = result[DATA_W-1];
      end
      default: begin
        result = '0;
        flags  = '0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_datapath.sv
// regfile_datapath: command responder for a sequencer.
// Accepts one control word per cmd_valid strobe, reads the 16x16 register
// file, runs the alu and writes the result back, returning latched flags,
// the latched result and a one-cycle done pulse.
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   cmd_valid / cmd_ready        - command strobe / accept window (IDLE only)
//   wEnable, opcode, Rdest_sel,
//   Rsrc_sel, Imm_sel, Imm_in    - control word, sampled only on accept
//   done                         - pulses in the EXEC cycle
//   Flags_out, result_out        - alu outputs latched at the end of EXEC
//   dbg_sel / dbg_data           - asynchronous debug read of the register file
// Command timing: accept in N, READ in N+1, EXEC (done) in N+2, results and
// register write visible from N+3.
module regfile_datapath
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 wEnable,
  input  logic [OP_W-1:0]      opcode,
  input  logic [REG_IDX_W-1:0] Rdest_sel,
  input  logic [REG_IDX_W-1:0] Rsrc_sel,
  input  logic                 Imm_sel,
  input  logic [DATA_W-1:0]    Imm_in,
  output logic                 done,
  output logic [FLAG_W-1:0]    Flags_out,
  output logic [DATA_W-1:0]    result_out,
  input  logic [REG_IDX_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]    dbg_data
);

  state_t                 state_q,   state_d;
  logic                   wen_q,     wen_d;
  logic [OP_W-1:0]        opcode_q,  opcode_d;
  logic [REG_IDX_W-1:0]   rdest_q,   rdest_d;
  logic [REG_IDX_W-1:0]   rsrc_q,    rsrc_d;
  logic                   imm_sel_q, imm_sel_d;
  logic [DATA_W-1:0]      imm_q,     imm_d;
  logic [DATA_W-1:0]      op_a_q,    op_a_d;
  logic [DATA_W-1:0]      op_b_q,    op_b_d;
  logic [DATA_W-1:0]      result_q,  result_d;
  logic [FLAG_W-1:0]      flags_q,   flags_d;
  logic                   done_q,    done_d;
  logic [DATA_W-1:0]      rf_q [NUM_REGS];
  logic [DATA_W-1:0]      rf_d [NUM_REGS];

  logic [DATA_W-1:0]      alu_result;
  logic [FLAG_W-1:0]      alu_flags;

  alu u_alu (
    .a      (op_a_q),
    .b      (op_b_q),
    .opcode (opcode_q),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_comb begin
    state_d   = state_q;
    wen_d     = wen_q;
    opcode_d  = opcode_q;
    rdest_d   = rdest_q;
    rsrc_d    = rsrc_q;
    imm_sel_d = imm_sel_q;
    imm_d     = imm_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    result_d  = result_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    rf_d      = rf_q;
    cmd_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          wen_d     = wEnable;
          opcode_d  = opcode;
          rdest_d   = Rdest_sel;
          rsrc_d    = Rsrc_sel;
          imm_sel_d = Imm_sel;
          imm_d     = Imm_in;
          state_d   = READ;
        end
      end
      READ: begin
        op_a_d  = rf_q[rdest_q];
        op_b_d  = imm_sel_q ? imm_q : rf_q[rsrc_q];
        // done is registered here so it is high throughout EXEC.
        done_d  = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        // WAIT leaves result, flags and the register file untouched.
        if (opcode_q != OP_WAIT) begin
          result_d = alu_result;
          flags_d  = alu_flags;
          if (wen_q) begin
            rf_d[rdest_q] = alu_result;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wen_q     <= 1'b0;
      opcode_q  <= '0;
      rdest_q   <= '0;
      rsrc_q    <= '0;
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wen_q     <= wen_d;
      opcode_q  <= opcode_d;
      rdest_q   <= rdest_d;
      rsrc_q    <= rsrc_d;
      imm_sel_q <= imm_sel_d;
      imm_q     <= imm_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign done       = done_q;
  assign Flags_out  = flags_q;
  assign result_out = result_q;
  assign dbg_data   = rf_q[dbg_sel];

endmodule

// File: tb/tb_regfile_datapath.sv
// tb_regfile_datapath: scoreboard bench for regfile_datapath.
// The stimulus process issues commands and, for each accepted one, updates
// an array-based reference model and queues the expected response. A
// separate monitor pops an entry on every done pulse and checks latency,
// result_out, Flags_out and the destination register via dbg_data.
module tb_regfile_datapath;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        wEnable;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_sel;
  logic [3:0]  Rsrc_sel;
  logic        Imm_sel;
  logic [15:0] Imm_in;
  logic        done;
  logic [4:0]  Flags_out;
  logic [15:0] result_out;
  logic [3:0]  dbg_sel;
  logic [15:0] dbg_data;

  regfile_datapath dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .wEnable    (wEnable),
    .opcode     (opcode),
    .Rdest_sel  (Rdest_sel),
    .Rsrc_sel   (Rsrc_sel),
    .Imm_sel    (Imm_sel),
    .Imm_in     (Imm_in),
    .done       (done),
    .Flags_out  (Flags_out),
    .result_out (result_out),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          issue;
    logic [3:0]  rdest;
    logic [15:0] rval;
    logic [15:0] res;
    logic [4:0]  flg;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rf_m [16];
  logic [15:0] res_m;
  logic [4:0]  flg_m;
  int          n_cmp = 0;
  int          n_bad = 0;

  // The monitor looks at the destination register; the main process takes
  // over the debug port only while nothing is in flight.
  logic [3:0]  mon_sel = 4'd0;
  logic [3:0]  chk_sel = 4'd0;
  bit          chk_mode = 1'b0;
  assign dbg_sel = chk_mode ? chk_sel : mon_sel;

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Reference alu computed with integer arithmetic.
  function automatic void alu_model(input logic [7:0] op, input logic [15:0] a,
                                    input logic [15:0] b, output logic [15:0] r,
                                    output logic [4:0] f);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int s;
    bit c = 1'b0;
    bit l = 1'b0;
    bit v = 1'b0;
    bit known = 1'b1;
    r = 16'h0;
    case (op)
      OP_ADD: begin
        s = ua + ub;
        r = s[15:0];
        c = (s > 65535);
        v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      OP_SUB, OP_CMP: begin
        s = ua - ub;
        r = s[15:0];
        l = (ua < ub);
        v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      OP_MOV: r = b;
      default: known = 1'b0;
    endcase
    if (known) f = {c, l, v, (r == 16'h0), (sa < 0 && op == OP_MOV && 1'b0) | r[15]};
    else f = 5'h0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) rf_m[i] = 16'h0;
    res_m = 16'h0;
    flg_m = 5'h0;
  endfunction

  task automatic issue(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic isel, input logic [15:0] imm, input logic wen,
                       input bit push, input bit busy);
    int          waited = 0;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [4:0]  f;
    exp_t        e;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL ready_timeout: got cmd_ready=0, expected 1");
      return;
    end
    opcode    = op;
    Rdest_sel = rd;
    Rsrc_sel  = rs;
    Imm_sel   = isel;
    Imm_in    = imm;
    wEnable   = wen;
    cmd_valid = 1'b1;
    if (push) begin
      a = rf_m[rd];
      b = isel ? imm : rf_m[rs];
      alu_model(op, a, b, r, f);
      if (op != OP_WAIT) begin
        res_m = r;
        flg_m = f;
        if (wen) rf_m[rd] = r;
      end
      e = '{issue: cyc, rdest: rd, rval: rf_m[rd], res: res_m, flg: flg_m};
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (busy) begin
      check("busy_ready", {15'h0, cmd_ready}, 16'h0);
      opcode    = OP_MOV;
      Imm_sel   = 1'b1;
      Imm_in    = 16'h5555;
      wEnable   = 1'b1;
      cmd_valid = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    Imm_in    = 16'($urandom);
    Rdest_sel = 4'($urandom);
    Rsrc_sel  = 4'($urandom);
    opcode    = 8'($urandom);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reg(string name, logic [3:0] idx, logic [15:0] exp);
    chk_sel  = idx;
    chk_mode = 1'b1;
    #1;
    check(name, dbg_data, exp);
    chk_mode = 1'b0;
  endtask

  // Monitor: one expected entry per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL spurious_done: got done=1, expected 0");
        end else begin
          e = exp_q.pop_front();
          check("latency", 16'(cyc - e.issue), 16'd2);
          mon_sel = e.rdest;
          @(negedge clk);
          check("result_out", result_out, e.res);
          check("Flags_out", {11'h0, Flags_out}, {11'h0, e.flg});
          if (!chk_mode) check("dbg_rdest", dbg_data, e.rval);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] fib_exp [10];
    logic [7:0]  rop;
    fib_exp = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34, 16'd55};
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    wEnable   = 1'b0;
    opcode    = 8'h0;
    Rdest_sel = 4'h0;
    Rsrc_sel  = 4'h0;
    Imm_sel   = 1'b0;
    Imm_in    = 16'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_done", {15'h0, done}, 16'h0);
    check("reset_result", result_out, 16'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {15'h0, cmd_ready}, 16'h1);

    // Immediate load, register add, WAIT hold.
    issue(OP_MOV, 4'd1, 4'd0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);
    issue(OP_MOV, 4'd2, 4'd0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);
    issue(OP_ADD, 4'd2, 4'd1, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0);
    wait_idle();
    check("add_result", result_out, 16'h0002);
    check("add_flags", {11'h0, Flags_out}, 16'h0000);
    check_reg("add_r2", 4'd2, 16'h0002);
    issue(OP_WAIT, 4'd2, 4'd1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    wait_idle();
    check("wait_result", result_out, 16'h0002);
    check_reg("wait_r2", 4'd2, 16'h0002);

    // Second strobe while busy must be dropped.
    issue(OP_MOV, 4'd3, 4'd0, 1'b1, 16'h00AA, 1'b1, 1'b1, 1'b1);
    wait_idle();
    check_reg("busy_r3", 4'd3, 16'h00AA);

    // Fibonacci as a sequencer would drive it.
    issue(OP_MOV, 4'd0, 4'd0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);
    issue(OP_MOV, 4'd1, 4'd0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);
    for (int i = 2; i < 10; i++) begin
      issue(OP_MOV, 4'(i), 4'(i - 1), 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
      issue(OP_ADD, 4'(i), 4'(i - 2), 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    end
    wait_idle();
    for (int i = 0; i < 10; i++) check_reg("fib", 4'(i), fib_exp[i]);

    // Randomized commands.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: rop = OP_WAIT;
        1: rop = OP_ADD;
        2: rop = OP_SUB;
        3: rop = OP_CMP;
        4: rop = OP_MOV;
        default: rop = 8'h33;
      endcase
      issue(rop, 4'($urandom), 4'($urandom), 1'($urandom), 16'($urandom),
            ($urandom_range(0, 3) != 0), 1'b1, ($urandom_range(0, 3) == 0));
    end
    wait_idle();

    // Reset asserted during EXEC drops the command.
    issue(OP_MOV, 4'd5, 4'd0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_done", {15'h0, done}, 16'h0);
    check("rst_result", result_out, 16'h0);
    check("rst_flags", {11'h0, Flags_out}, 16'h0);
    for (int i = 0; i < 16; i++) check_reg("rst_rf", 4'(i), 16'h0);
    reset_n = 1'b1;
    model_reset();
    issue(OP_ADD, 4'd5, 4'd0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    wait_idle();

    check("queue_empty", 16'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
